control_unit: RTL and testbench

//  Multi-cycle fetch/decode/execute sequencer for the 16-bit RISC core. Sits directly upstream of
//  the memory + datapath pair and generates every mb_* / dp_* control strobe they consume. It

---
 rtl/control_unit.sv | 180 ++++++++++++++++++
 tb/tb_control_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer: owns PC, IR and zero flag; drives all mb_*/dp_* strobes.
// Latency: ALU/LDI/ST/JMP/JZ/NOP = 2+MEM_WAIT cycles, LD = 4+2*MEM_WAIT cycles, from first FETCH cycle.
// Backpressure: none; memory is fixed-latency (MEM_WAIT read-wait cycles), start is the only handshake.
module control_unit #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter int         MEM_WAIT = 1
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        start,
  output logic        halted,
  output logic [7:0]  pc_out,
  output logic [15:0] ir_out,
  output logic        mb_sel,
  output logic [7:0]  mb_pc_addr,
  output logic [7:0]  mb_cu_addr,
  output logic        mb_mem_read,
  output logic        mb_mem_write,
  input  logic [15:0] mb_data_out,
  output logic [7:0]  dp_imm,
  output logic [1:0]  dp_sel,
  output logic [3:0]  dp_write_addr,
  output logic        dp_write,
  output logic [3:0]  dp_a_addr,
  output logic        dp_a_read,
  output logic [3:0]  dp_b_addr,
  output logic        dp_b_read,
  output logic [3:0]  dp_alu_sel,
  input  logic        dp_zf_flag
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MREAD = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // Wait counter compares against the last read-wait cycle index.
  localparam logic [1:0] LP_WAIT = 2'(MEM_WAIT);

  state_t      r_state;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;
  logic        r_zq;
  logic [1:0]  r_wait;

  logic [3:0]  w_op;
  logic [3:0]  w_rd;
  logic [3:0]  w_rs1;
  logic [3:0]  w_rs2;
  logic [7:0]  w_imm;
  logic        w_is_alu;
  logic        w_wait_done;

  assign w_op        = r_ir[15:12];
  assign w_rd        = r_ir[11:8];
  assign w_rs1       = r_ir[7:4];
  assign w_rs2       = r_ir[3:0];
  assign w_imm       = r_ir[7:0];
  assign w_is_alu    = (w_op >= 4'h4) && (w_op <= 4'hB);
  assign w_wait_done = (r_wait == LP_WAIT);

  // Sequencer state, PC, IR and latched zero flag.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_pc    <= PC_RESET;
      r_ir    <= 16'h0000;
      r_zq    <= 1'b0;
      r_wait  <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_FETCH;
        end
        S_FETCH: begin
          if (w_wait_done) begin
            r_ir    <= mb_data_out;
            r_pc    <= r_pc + 8'd1;
            r_wait  <= 2'd0;
            r_state <= S_EXEC;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_EXEC: begin
          case (w_op)
            4'h2: r_state <= S_MREAD;
            4'hC: begin
              if (r_zq) r_pc <= w_imm;
              r_state <= S_FETCH;
            end
            4'hD: begin
              r_pc    <= w_imm;
              r_state <= S_FETCH;
            end
            4'hF: r_state <= S_HALT;
            default: begin
              // Only ALU ops refresh the zero flag; loads and immediates leave it alone.
              if (w_is_alu) r_zq <= dp_zf_flag;
              r_state <= S_FETCH;
            end
          endcase
        end
        S_MREAD: begin
          if (w_wait_done) begin
            r_wait  <= 2'd0;
            r_state <= S_WB;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_WB:    r_state <= S_FETCH;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pc_out        = r_pc;
  assign ir_out        = r_ir;
  assign mb_pc_addr    = r_pc;
  assign mb_cu_addr    = w_imm;
  assign dp_imm        = w_imm;
  assign dp_write_addr = w_rd;

  // Strobe decode from state and IR; decoding combinationally lets reset kill a write in the same cycle.
  always_comb begin
    halted       = 1'b0;
    mb_sel       = 1'b0;
    mb_mem_read  = 1'b0;
    mb_mem_write = 1'b0;
    dp_sel       = 2'd0;
    dp_write     = 1'b0;
    dp_a_addr    = 4'd0;
    dp_a_read    = 1'b0;
    dp_b_addr    = 4'd0;
    dp_b_read    = 1'b0;
    dp_alu_sel   = 4'd0;
    case (r_state)
      S_FETCH: begin
        mb_mem_read = 1'b1;
      end
      S_EXEC: begin
        if (w_is_alu) begin
          dp_a_addr  = w_rs1;
          dp_a_read  = 1'b1;
          dp_b_addr  = w_rs2;
          dp_b_read  = 1'b1;
          dp_alu_sel = w_op - 4'd4;
          dp_write   = 1'b1;
        end else if (w_op == 4'h1) begin
          dp_sel   = 2'd2;
          dp_write = 1'b1;
        end else if (w_op == 4'h3) begin
          dp_a_addr    = w_rd;
          dp_a_read    = 1'b1;
          mb_sel       = 1'b1;
          mb_mem_write = 1'b1;
        end
      end
      S_MREAD: begin
        mb_sel      = 1'b1;
        mb_mem_read = 1'b1;
      end
      S_WB: begin
        dp_sel   = 2'd1;
        dp_write = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: small program memory, zero-flag driver and write-event scoreboard.
// Latency: checks LD takes 6 cycles and that strobes react to reset in the same cycle.
// Backpressure: none in the DUT; the bench memory answers combinationally.
module tb_control_unit;

  logic        CLK100MHZ;
  logic        rst_n;
  logic        start;
  logic        halted;
  logic [7:0]  pc_out;
  logic [15:0] ir_out;
  logic        mb_sel;
  logic [7:0]  mb_pc_addr;
  logic [7:0]  mb_cu_addr;
  logic        mb_mem_read;
  logic        mb_mem_write;
  logic [15:0] mb_data_out;
  logic [7:0]  dp_imm;
  logic [1:0]  dp_sel;
  logic [3:0]  dp_write_addr;
  logic        dp_write;
  logic [3:0]  dp_a_addr;
  logic        dp_a_read;
  logic [3:0]  dp_b_addr;
  logic        dp_b_read;
  logic [3:0]  dp_alu_sel;
  logic        dp_zf_flag;

  logic        r_zf;
  logic [15:0] r_mem [256];
  int          n_chk;
  int          n_pass;

  // One register-file or memory write as seen on the strobes.
  typedef struct packed {
    logic       wr;
    logic       mw;
    logic       mbsel;
    logic [1:0] sel;
    logic [3:0] waddr;
    logic [3:0] alu;
    logic [3:0] a;
    logic       ard;
    logic [3:0] b;
    logic       brd;
    logic [7:0] imm;
    logic [7:0] pc;
  } ev_t;

  ev_t sb_q [$];

  logic [72:0] w_all;
  logic [14:0] w_strobes;

  control_unit #(.PC_RESET(8'h00), .MEM_WAIT(1)) dut (
    .CLK100MHZ    (CLK100MHZ),
    .rst_n        (rst_n),
    .start        (start),
    .halted       (halted),
    .pc_out       (pc_out),
    .ir_out       (ir_out),
    .mb_sel       (mb_sel),
    .mb_pc_addr   (mb_pc_addr),
    .mb_cu_addr   (mb_cu_addr),
    .mb_mem_read  (mb_mem_read),
    .mb_mem_write (mb_mem_write),
    .mb_data_out  (mb_data_out),
    .dp_imm       (dp_imm),
    .dp_sel       (dp_sel),
    .dp_write_addr(dp_write_addr),
    .dp_write     (dp_write),
    .dp_a_addr    (dp_a_addr),
    .dp_a_read    (dp_a_read),
    .dp_b_addr    (dp_b_addr),
    .dp_b_read    (dp_b_read),
    .dp_alu_sel   (dp_alu_sel),
    .dp_zf_flag   (dp_zf_flag)
  );

  initial CLK100MHZ = 1'b0;
  always #5 CLK100MHZ = ~CLK100MHZ;

  // Memory answers combinationally; zero flag is inverted outside ALU cycles so a stray sample shows up.
  always_comb begin
    mb_data_out = mb_sel ? r_mem[mb_cu_addr] : r_mem[mb_pc_addr];
    dp_zf_flag  = (dp_a_read && dp_b_read) ? r_zf : ~r_zf;
  end

  assign w_all = {halted, pc_out, ir_out, mb_sel, mb_pc_addr, mb_cu_addr, mb_mem_read,
                  mb_mem_write, dp_imm, dp_sel, dp_write_addr, dp_write, dp_a_addr,
                  dp_a_read, dp_b_addr, dp_b_read, dp_alu_sel};
  assign w_strobes = {mb_sel, mb_mem_read, mb_mem_write, dp_sel, dp_write, dp_a_read,
                      dp_b_read, dp_alu_sel, dp_a_addr[3:1]};

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic ev_t mk_ev(input logic wr, input logic mw, input logic mbsel,
                                input logic [1:0] sel, input logic [3:0] waddr,
                                input logic [3:0] alu, input logic [3:0] a, input logic ard,
                                input logic [3:0] b, input logic brd,
                                input logic [7:0] imm, input logic [7:0] pc);
    mk_ev = '{wr, mw, mbsel, sel, waddr, alu, a, ard, b, brd, imm, pc};
  endfunction

  function automatic ev_t obs_ev();
    obs_ev = mk_ev(dp_write, mb_mem_write, mb_sel, dp_sel, dp_write_addr, dp_alu_sel,
                   dp_a_addr, dp_a_read, dp_b_addr, dp_b_read, dp_imm, pc_out);
  endfunction

  // Scoreboard: every write strobe pops the next expected event.
  always @(negedge CLK100MHZ) begin
    if (rst_n && (dp_write || mb_mem_write)) begin
      if (sb_q.size() == 0) chk("sb_extra", 80'(sb_q.size()), 80'(1));
      else chk("sb_event", 80'(obs_ev()), 80'(sb_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic mem_fill();
    for (int i = 0; i < 256; i++) r_mem[i] = 16'hF000;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_halt(input string tag, input logic [7:0] exp_pc);
    for (int i = 0; i < 200 && !halted; i++) tick(1);
    chk({tag, "_halted"}, 80'(halted), 80'(1'b1));
    chk({tag, "_pc"}, 80'(pc_out), 80'(exp_pc));
    chk({tag, "_drain"}, 80'(sb_q.size()), 80'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    r_zf   = 1'b0;
    mem_fill();
    tick(2);
    chk("reset_outs", 80'(w_all), 80'(0));
    rst_n = 1'b1;
    tick(1);

    // Reset during EXEC of a store: write strobe drops immediately, DUT returns to idle.
    r_mem[0] = 16'h3405;
    pulse_start();
    tick(2);
    chk("st_exec_wr", 80'(mb_mem_write), 80'(1'b1));
    rst_n = 1'b0;
    #1;
    chk("st_rst_wr", 80'(mb_mem_write), 80'(1'b0));
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rst_release_outs", 80'(w_all), 80'(0));
    tick(3);
    chk("idle_no_fetch", 80'(w_all), 80'(0));

    // LDI then ALU op 4.
    mem_fill();
    r_mem[0] = 16'h1105;
    r_mem[1] = 16'h4211;
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd2, 4'd1, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h05, 8'h01));
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd0, 4'd2, 4'd0, 4'd1, 1'b1, 4'd1, 1'b1, 8'h11, 8'h02));
    pulse_start();
    wait_halt("ldi_alu", 8'h03);
    do_reset();

    // LD with read-wait, then ST.
    mem_fill();
    r_mem[0]    = 16'h2320;
    r_mem[8'h20] = 16'hBEEF;
    r_mem[1]    = 16'h3305;
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd1, 4'd3, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h20, 8'h01));
    sb_q.push_back(mk_ev(1'b0, 1'b1, 1'b1, 2'd0, 4'd3, 4'd0, 4'd3, 1'b1, 4'd0, 1'b0, 8'h05, 8'h02));
    pulse_start();
    tick(3);
    chk("ld_mread", 80'({mb_sel, mb_mem_read, mb_cu_addr, mb_data_out}), 80'({2'b11, 8'h20, 16'hBEEF}));
    n = 4;
    while (!(dp_write && dp_sel == 2'd1) && n < 20) begin
      tick(1);
      n++;
    end
    chk("ld_wb_cycle", 80'(n), 80'(6));
    tick(1);
    chk("ld_next_fetch", 80'({mb_mem_read, mb_sel}), 80'(2'b10));
    wait_halt("ld_st", 8'h03);
    do_reset();

    // ALU sets zq, LDI leaves it, JZ taken.
    mem_fill();
    r_zf     = 1'b1;
    r_mem[0] = 16'h5123;
    r_mem[1] = 16'h1707;
    r_mem[2] = 16'hC040;
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd0, 4'd1, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 8'h23, 8'h01));
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd2, 4'd7, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h07, 8'h02));
    pulse_start();
    wait_halt("jz_taken", 8'h41);
    do_reset();

    // Reset clears zq: JZ first is not taken.
    mem_fill();
    r_mem[0] = 16'hC040;
    pulse_start();
    wait_halt("jz_after_rst", 8'h02);
    do_reset();

    // ALU clears zq: JZ falls through.
    mem_fill();
    r_zf     = 1'b0;
    r_mem[0] = 16'h5123;
    r_mem[1] = 16'h1707;
    r_mem[2] = 16'hC040;
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd0, 4'd1, 4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 8'h23, 8'h01));
    sb_q.push_back(mk_ev(1'b1, 1'b0, 1'b0, 2'd2, 4'd7, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 8'h07, 8'h02));
    pulse_start();
    wait_halt("jz_not_taken", 8'h04);
    do_reset();

    // JMP to FE, JMP FF, NOP at FF: PC wraps to 00.
    mem_fill();
    r_mem[0]     = 16'hD0FE;
    r_mem[8'hFE] = 16'hD0FF;
    r_mem[8'hFF] = 16'h0000;
    pulse_start();
    for (int i = 0; i < 50 && pc_out != 8'hFF; i++) tick(1);
    chk("jmp_ff", 80'(pc_out), 80'(8'hFF));
    r_mem[0] = 16'hF000;
    for (int i = 0; i < 50 && pc_out == 8'hFF; i++) tick(1);
    chk("pc_wrap", 80'(pc_out), 80'(8'h00));
    wait_halt("wrap", 8'h01);
    do_reset();

    // HALT: strobes quiet and start ignored, only reset leaves.
    mem_fill();
    pulse_start();
    wait_halt("halt", 8'h01);
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      tick(1);
      chk("halt_strobes", 80'({halted, w_strobes}), 80'({1'b1, 15'd0}));
    end
    start = 1'b0;
    do_reset();
    chk("halt_reset_outs", 80'(w_all), 80'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
